// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit (state encoding, default widths, wrap address).
package lsu_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [ADDR_W_DEF-1:0] WRAP_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Byte-lane select and extension of memory read data for loads.
// Define LSU_BYTE_SIGN_EXT_EN to sign-extend byte loads; otherwise they are zero-extended.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rd_data,
  input  logic              word,
  output logic [DATA_W-1:0] load_data_c
);

  localparam int unsigned LANE_W = DATA_W / 2;

  logic [DATA_W-LANE_W-1:0] fill_c;

  // Upper lane of a byte read is undriven by the memory, so it never reaches the result.
  always_comb begin
`ifdef LSU_BYTE_SIGN_EXT_EN
    fill_c = {(DATA_W-LANE_W){rd_data[LANE_W-1]}};
`else
    fill_c = '0;
`endif
    load_data_c = word ? rd_data : {fill_c, rd_data[LANE_W-1:0]};
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the byte-addressed data memory.
// Byte-load extension is selected by LSU_BYTE_SIGN_EXT_EN (see lsu_load_align).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ALLOW_WRAP = 1
) (
  input  logic              lsu_clk,
  input  logic              lsu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              mem_addr_valid,
  output logic              word_op,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_e state;
  lsu_state_e next_state;

  logic rq_write;
  logic rq_word;

  logic accept_c;
  logic wrap_err_c;
  logic [DATA_W-1:0] load_data_c;

  logic              req_ready_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              resp_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_d;
  logic              mem_rd_en_d;
  logic              mem_wr_en_d;
  logic              mem_addr_valid_d;
  logic              word_op_d;

  assign accept_c   = req_valid && req_ready;
  assign wrap_err_c = (ALLOW_WRAP == 0) && req_word && (req_addr == ADDR_W'(WRAP_ADDR));

  lsu_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rd_data     (mem_data_out),
    .word        (rq_word),
    .load_data_c (load_data_c)
  );

  // State register
  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request attributes needed after the bus phase
  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      rq_write <= 1'b0;
      rq_word  <= 1'b0;
    end else if (accept_c) begin
      rq_write <= req_write;
      rq_word  <= req_word;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c) next_state = wrap_err_c ? RESP : ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle output values; the mem_* flops themselves hold the request address/data during ACCESS
  always_comb begin
    req_ready_d      = (next_state == IDLE);
    resp_valid_d     = (next_state == RESP);
    resp_rdata_d     = resp_rdata;
    resp_err_d       = resp_err;
    mem_addr_d       = '0;
    mem_data_in_d    = '0;
    mem_rd_en_d      = 1'b0;
    mem_wr_en_d      = 1'b0;
    mem_addr_valid_d = 1'b0;
    word_op_d        = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          resp_rdata_d = '0;
          resp_err_d   = wrap_err_c;
          if (!wrap_err_c) begin
            mem_addr_valid_d = 1'b1;
            mem_addr_d       = req_addr;
            mem_data_in_d    = req_wdata;
            word_op_d        = req_word;
            mem_rd_en_d      = !req_write;
            mem_wr_en_d      = req_write;
          end
        end
      end
      ACCESS: begin
        resp_rdata_d = rq_write ? '0 : load_data_c;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_addr_valid <= 1'b0;
      word_op        <= 1'b0;
    end else begin
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_rdata     <= resp_rdata_d;
      resp_err       <= resp_err_d;
      mem_addr       <= mem_addr_d;
      mem_data_in    <= mem_data_in_d;
      mem_rd_en      <= mem_rd_en_d;
      mem_wr_en      <= mem_wr_en_d;
      mem_addr_valid <= mem_addr_valid_d;
      word_op        <= word_op_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory environment plus a byte-array reference model,
// one wrap-allowed instance (main) and one wrap-rejecting instance (nw_*).
module tb_load_store_unit;

  logic        lsu_clk = 1'b0;
  logic        lsu_rst;
  logic        req_valid, req_ready, req_write, req_word;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_rd_en, mem_wr_en, mem_addr_valid, word_op;

  logic        nw_req_valid, nw_req_ready, nw_req_write, nw_req_word;
  logic [7:0]  nw_req_addr;
  logic [15:0] nw_req_wdata;
  logic        nw_resp_valid, nw_resp_ready, nw_resp_err;
  logic [15:0] nw_resp_rdata;
  logic [7:0]  nw_mem_addr;
  logic [15:0] nw_mem_data_in, nw_mem_data_out;
  logic        nw_mem_rd_en, nw_mem_wr_en, nw_mem_addr_valid, nw_word_op;

  int checks = 0;
  int failures = 0;
  int quiet_viol = 0;
  logic mon_en = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] model_mem [256];

  always #5 lsu_clk = ~lsu_clk;

  load_store_unit #(.ADDR_W(8), .DATA_W(16), .ALLOW_WRAP(1)) u_dut (
    .lsu_clk(lsu_clk), .lsu_rst(lsu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr_valid(mem_addr_valid), .word_op(word_op), .mem_data_out(mem_data_out)
  );

  load_store_unit #(.ADDR_W(8), .DATA_W(16), .ALLOW_WRAP(0)) u_nw (
    .lsu_clk(lsu_clk), .lsu_rst(lsu_rst),
    .req_valid(nw_req_valid), .req_ready(nw_req_ready), .req_write(nw_req_write), .req_word(nw_req_word),
    .req_addr(nw_req_addr), .req_wdata(nw_req_wdata),
    .resp_valid(nw_resp_valid), .resp_ready(nw_resp_ready), .resp_rdata(nw_resp_rdata), .resp_err(nw_resp_err),
    .mem_addr(nw_mem_addr), .mem_data_in(nw_mem_data_in), .mem_rd_en(nw_mem_rd_en), .mem_wr_en(nw_mem_wr_en),
    .mem_addr_valid(nw_mem_addr_valid), .word_op(nw_word_op), .mem_data_out(nw_mem_data_out)
  );

  function automatic logic [7:0] init_byte(input int i);
    if (i == 6) return 8'hB3;
    if (i == 7) return 8'h47;
    if (i == 8) return 8'hD8;
    if (i == 9) return 8'h8E;
    return 8'h00;
  endfunction

  function automatic logic [15:0] ext8(input logic [7:0] b);
`ifdef LSU_BYTE_SIGN_EXT_EN
    return {{8{b[7]}}, b};
`else
    return {8'h00, b};
`endif
  endfunction

  // Memory environment: reset-initialised, commits stores on the edge ending the access
  always @(posedge lsu_clk) begin
    if (lsu_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (mem_addr_valid && mem_wr_en) begin
      if (word_op) begin
        mem[mem_addr]               <= mem_data_in[15:8];
        mem[8'(mem_addr + 8'd1)]    <= mem_data_in[7:0];
      end else begin
        mem[mem_addr] <= mem_data_in[7:0];
      end
    end
  end

  // Byte reads leave the upper lane as garbage to prove it is discarded
  always_comb mem_data_out = word_op ? {mem[mem_addr], mem[8'(mem_addr + 8'd1)]} : {8'hA5, mem[mem_addr]};

  always @(negedge lsu_clk) begin
    if (mon_en) begin
      if (!mem_addr_valid && (mem_rd_en || mem_wr_en || word_op || mem_addr != 8'h00 || mem_data_in != 16'h0000))
        quiet_viol <= quiet_viol + 1;
      if (mem_addr_valid && (mem_rd_en == mem_wr_en)) quiet_viol <= quiet_viol + 1;
      if (!nw_mem_addr_valid && (nw_mem_rd_en || nw_mem_wr_en || nw_word_op || nw_mem_addr != 8'h00 || nw_mem_data_in != 16'h0000))
        quiet_viol <= quiet_viol + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_byte(i);
  endtask

  task automatic run_txn(input logic wr, input logic wd, input logic [7:0] a, input logic [15:0] wdat, input int stall);
    logic [15:0] exp_d;
    int n;
    int acc;
    if (wr) begin
      exp_d = 16'h0000;
      if (wd) begin
        model_mem[a] = wdat[15:8];
        model_mem[8'(a + 8'd1)] = wdat[7:0];
      end else begin
        model_mem[a] = wdat[7:0];
      end
    end else begin
      exp_d = wd ? {model_mem[a], model_mem[8'(a + 8'd1)]} : ext8(model_mem[a]);
    end
    @(negedge lsu_clk);
    req_valid = 1'b1; req_write = wr; req_word = wd; req_addr = a; req_wdata = wdat; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge lsu_clk); n++; end
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge lsu_clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_word = 1'($urandom);
    req_addr = 8'($urandom); req_wdata = 16'($urandom);
    n = 0; acc = 0;
    while (n < 20) begin
      @(negedge lsu_clk); n++;
      if (mem_addr_valid) begin
        acc++;
        check_eq("acc_rd_en", 32'(mem_rd_en), 32'(!wr));
        check_eq("acc_wr_en", 32'(mem_wr_en), 32'(wr));
        check_eq("acc_word_op", 32'(word_op), 32'(wd));
        check_eq("acc_addr", 32'(mem_addr), 32'(a));
        if (wr) check_eq("acc_wdata", 32'(wd ? mem_data_in : {8'h00, mem_data_in[7:0]}),
                         32'(wd ? wdat : {8'h00, wdat[7:0]}));
      end
      if (resp_valid) break;
    end
    check_eq("resp_latency", 32'(n), 32'd2);
    check_eq("access_cycles", 32'(acc), 32'd1);
    check_eq("resp_rdata", 32'(resp_rdata), 32'(exp_d));
    check_eq("resp_err", 32'(resp_err), 32'd0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge lsu_clk);
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", 32'(resp_rdata), 32'(exp_d));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_no_access", 32'(mem_addr_valid), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge lsu_clk); #1;
    resp_ready = 1'($urandom);
    @(negedge lsu_clk);
    check_eq("post_hs_valid", 32'(resp_valid), 32'd0);
    check_eq("post_hs_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  task automatic nw_txn(input logic wr, input logic wd, input logic [7:0] a, input logic [15:0] wdat,
                        input logic exp_err, input logic [15:0] exp_d, input int exp_lat);
    int n;
    int en_seen;
    @(negedge lsu_clk);
    nw_req_valid = 1'b1; nw_req_write = wr; nw_req_word = wd; nw_req_addr = a; nw_req_wdata = wdat;
    nw_resp_ready = 1'b0;
    check_eq("nw_req_ready", 32'(nw_req_ready), 32'd1);
    @(posedge lsu_clk); #1;
    nw_req_valid = 1'b0;
    n = 0; en_seen = 0;
    while (n < 20) begin
      @(negedge lsu_clk); n++;
      if (nw_mem_addr_valid || nw_mem_rd_en || nw_mem_wr_en) en_seen++;
      if (nw_resp_valid) break;
    end
    check_eq("nw_latency", 32'(n), 32'(exp_lat));
    check_eq("nw_resp_err", 32'(nw_resp_err), 32'(exp_err));
    check_eq("nw_resp_rdata", 32'(nw_resp_rdata), 32'(exp_d));
    check_eq("nw_enable_cycles", 32'(en_seen), exp_err ? 32'd0 : 32'd1);
    nw_resp_ready = 1'b1;
    @(posedge lsu_clk); #1;
    nw_resp_ready = 1'b0;
    @(negedge lsu_clk);
    check_eq("nw_post_valid", 32'(nw_resp_valid), 32'd0);
    check_eq("nw_post_err", 32'(nw_resp_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int rv_seen;
    logic [7:0] a;
    int r;
    lsu_rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000; resp_ready = 1'b0;
    nw_req_valid = 1'b0; nw_req_write = 1'b0; nw_req_word = 1'b0; nw_req_addr = 8'h00; nw_req_wdata = 16'h0000;
    nw_resp_ready = 1'b0; nw_mem_data_out = 16'h1357;
    repeat (2) @(posedge lsu_clk);
    @(negedge lsu_clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_mem_ctl", 32'({mem_addr_valid, mem_rd_en, mem_wr_en, word_op}), 32'd0);
    check_eq("rst_mem_bus", 32'({mem_addr, mem_data_in}), 32'd0);
    lsu_rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    run_txn(1'b0, 1'b1, 8'h06, 16'h0000, 0);
    run_txn(1'b0, 1'b0, 8'h08, 16'h0000, 0);
    run_txn(1'b1, 1'b1, 8'h20, 16'hBEEF, 0);
    run_txn(1'b0, 1'b1, 8'h20, 16'h0000, 0);
    run_txn(1'b1, 1'b0, 8'h21, 16'h1234, 0);
    run_txn(1'b0, 1'b1, 8'h20, 16'h0000, 0);
    run_txn(1'b1, 1'b1, 8'hFF, 16'hCAFE, 0);
    @(negedge lsu_clk);
    check_eq("wrap_mem_ff", 32'(mem[255]), 32'h00CA);
    check_eq("wrap_mem_00", 32'(mem[0]), 32'h00FE);
    run_txn(1'b0, 1'b1, 8'hFF, 16'h0000, 0);
    run_txn(1'b0, 1'b0, 8'hFF, 16'h0000, 0);
    run_txn(1'b0, 1'b1, 8'h07, 16'h0000, 5);

    // Reset landing in the ACCESS cycle of a load
    @(negedge lsu_clk);
    req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_addr = 8'h07; resp_ready = 1'b1;
    @(posedge lsu_clk); #1;
    req_valid = 1'b0;
    @(negedge lsu_clk);
    check_eq("rst_mid_in_access", 32'(mem_addr_valid), 32'd1);
    lsu_rst = 1'b1;
    @(posedge lsu_clk); #1;
    lsu_rst = 1'b0;
    model_reset();
    @(negedge lsu_clk);
    check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mid_mem_ctl", 32'({mem_addr_valid, mem_rd_en, mem_wr_en, word_op}), 32'd0);
    check_eq("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    rv_seen = 0;
    if (resp_valid) rv_seen++;
    repeat (5) begin
      @(negedge lsu_clk);
      if (resp_valid) rv_seen++;
    end
    check_eq("rst_mid_no_resp", 32'(rv_seen), 32'd0);
    resp_ready = 1'b0;

    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 8'hFF;
      else if (r < 7) a = 8'($urandom_range(0, 15));
      else a = 8'($urandom);
      run_txn(1'($urandom), 1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
    end

    nw_txn(1'b1, 1'b1, 8'hFF, 16'hCAFE, 1'b1, 16'h0000, 1);
    nw_txn(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b1, 16'h0000, 1);
    nw_txn(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, ext8(8'h57), 2);
    nw_txn(1'b1, 1'b0, 8'hFF, 16'h00AA, 1'b0, 16'h0000, 2);
    nw_txn(1'b0, 1'b1, 8'h10, 16'h0000, 1'b0, 16'h1357, 2);
    nw_txn(1'b0, 1'b1, 8'hFE, 16'h0000, 1'b0, 16'h1357, 2);

    @(negedge lsu_clk);
    check_eq("bus_quiet_outside_access", 32'(quiet_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
